argmax_stream: RTL

Streaming argmax stage that sits directly downstream of a fully-connected layer such as `layer_5_2_5_9`. It consumes that layer's output stream of M signed T-bit words per vector over a valid/ready handshake. For each vector it returns the index of the largest word, and optionally the word's value, as a single registered result beat. The result register is separate from the running-max state, so the block accepts the next vector while a result is still waiting on the output.

---
 rtl/argmax_stream.sv | 112 +++++++++++
 1 files changed

// File: rtl/argmax_stream.sv
// Streaming argmax over M signed T-bit words per vector, with a registered result beat.
// Define ARGMAX_VALUE_OUT_EN to add the max_out port carrying the winning value.
module argmax_stream #(
    parameter int M    = 5,
    parameter int T    = 9,
    parameter int logM = $clog2(M)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic signed [T-1:0] data_in,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [logM-1:0]     data_out
`ifdef ARGMAX_VALUE_OUT_EN
    ,
    output logic signed [T-1:0] max_out
`endif
);

    localparam logic [logM-1:0] LAST = logM'(M - 1);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } res_state_t;

    function automatic logic is_greater(input logic signed [T-1:0] a,
                                        input logic signed [T-1:0] b);
        return a > b;
    endfunction

    res_state_t          state;
    logic [logM-1:0]     cnt;
    logic signed [T-1:0] best_p0;
    logic [logM-1:0]     best_idx_p0;

    logic                last_word;
    logic                accept;
    logic                vld_p0;
    logic                new_max;
    logic [logM-1:0]     fin_idx;
`ifdef ARGMAX_VALUE_OUT_EN
    logic signed [T-1:0] fin_max;
`endif

    // Only the last word of a vector can stall, and only behind an undelivered result.
    always_comb begin
        last_word = (cnt == LAST);
        s_ready   = !(last_word && m_valid && !m_ready);
        accept    = s_valid && s_ready;
        vld_p0    = accept && last_word;
        new_max   = is_greater(data_in, best_p0);
        fin_idx   = new_max ? cnt : best_idx_p0;
`ifdef ARGMAX_VALUE_OUT_EN
        fin_max   = new_max ? data_in : best_p0;
`endif
    end

    // Stage p0: running maximum; element 0 seeds it, later words replace only on strict greater.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt         <= '0;
            best_p0     <= '0;
            best_idx_p0 <= '0;
        end else if (accept) begin
            if (cnt == '0) begin
                best_p0     <= data_in;
                best_idx_p0 <= '0;
            end else if (new_max) begin
                best_p0     <= data_in;
                best_idx_p0 <= cnt;
            end
            cnt <= last_word ? '0 : cnt + 1'b1;
        end
    end

    // Result register: a completing vector always loads, even over a result consumed this edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= EMPTY;
            m_valid  <= 1'b0;
            data_out <= '0;
`ifdef ARGMAX_VALUE_OUT_EN
            max_out  <= '0;
`endif
        end else begin
            unique case (state)
                EMPTY: begin
                    if (vld_p0) begin
                        state   <= FULL;
                        m_valid <= 1'b1;
                    end
                end
                FULL: begin
                    if (!vld_p0 && m_ready) begin
                        state   <= EMPTY;
                        m_valid <= 1'b0;
                    end
                end
            endcase
            if (vld_p0) begin
                data_out <= fin_idx;
`ifdef ARGMAX_VALUE_OUT_EN
                max_out  <= fin_max;
`endif
            end
        end
    end

endmodule
